// File: rtl/opl3_timers.sv
// OPL3 Timer 1 / Timer 2 with overflow flags, masks and IRQ status.
// Driven by the sample-rate clock enable; all logic in the clk domain.
module opl3_timers #(
  parameter int SAMPLES_PER_T1_TICK = 4,
  parameter int T2_TICK_DIV         = 4
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       sample_clk_en,
  input  logic [7:0] timer1_preset,
  input  logic [7:0] timer2_preset,
  input  logic       st1,
  input  logic       st2,
  input  logic       mt1,
  input  logic       mt2,
  input  logic       irq_rst,
  output logic       ft1,
  output logic       ft2,
  output logic       irq,
  output logic [7:0] status
);

  localparam int P1W =
    (SAMPLES_PER_T1_TICK > 1) ? $clog2(SAMPLES_PER_T1_TICK) : 1;
  localparam int P2W =
    (T2_TICK_DIV > 1) ? $clog2(T2_TICK_DIV) : 1;
  localparam logic [P1W-1:0] P1_LAST = P1W'(SAMPLES_PER_T1_TICK - 1);
  localparam logic [P2W-1:0] P2_LAST = P2W'(T2_TICK_DIV - 1);

  logic [P1W-1:0] r_presc1;
  logic [P2W-1:0] r_presc2;
  logic [7:0]     r_cnt1;
  logic [7:0]     r_cnt2;
  logic           r_ft1;
  logic           r_ft2;

  logic w_t1_tick;
  logic w_t2_tick;
  logic w_ov1;
  logic w_ov2;

  assign w_t1_tick = sample_clk_en && (r_presc1 == P1_LAST);
  assign w_t2_tick = w_t1_tick && (r_presc2 == P2_LAST);
  assign w_ov1     = st1 && w_t1_tick && (r_cnt1 == 8'hFF);
  assign w_ov2     = st2 && w_t2_tick && (r_cnt2 == 8'hFF);

  // Free-running prescalers: samples -> T1 ticks -> T2 ticks.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_presc1 <= '0;
      r_presc2 <= '0;
    end else begin
      if (sample_clk_en) begin
        if (w_t1_tick) r_presc1 <= '0;
        else           r_presc1 <= r_presc1 + P1W'(1);
      end
      if (w_t1_tick) begin
        if (w_t2_tick) r_presc2 <= '0;
        else           r_presc2 <= r_presc2 + P2W'(1);
      end
    end
  end

  // Timer 1 up-counter: preloaded while stopped, reloads on overflow.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_cnt1 <= 8'h00;
    end else if (!st1) begin
      r_cnt1 <= timer1_preset;
    end else if (w_t1_tick) begin
      if (r_cnt1 == 8'hFF) r_cnt1 <= timer1_preset;
      else                 r_cnt1 <= r_cnt1 + 8'd1;
    end
  end

  // Timer 2 up-counter: preloaded while stopped, reloads on overflow.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_cnt2 <= 8'h00;
    end else if (!st2) begin
      r_cnt2 <= timer2_preset;
    end else if (w_t2_tick) begin
      if (r_cnt2 == 8'hFF) r_cnt2 <= timer2_preset;
      else                 r_cnt2 <= r_cnt2 + 8'd1;
    end
  end

  // Sticky flags: mask beats irq_rst, irq_rst beats a same-cycle overflow.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_ft1 <= 1'b0;
      r_ft2 <= 1'b0;
    end else begin
      if (mt1)          r_ft1 <= 1'b0;
      else if (irq_rst) r_ft1 <= 1'b0;
      else if (w_ov1)   r_ft1 <= 1'b1;

      if (mt2)          r_ft2 <= 1'b0;
      else if (irq_rst) r_ft2 <= 1'b0;
      else if (w_ov2)   r_ft2 <= 1'b1;
    end
  end

  assign ft1    = r_ft1;
  assign ft2    = r_ft2;
  assign irq    = r_ft1 | r_ft2;
  assign status = {r_ft1 | r_ft2, r_ft1, r_ft2, 5'b00000};

endmodule
